// File: rtl/fmul_arb_pkg.sv
// fmul_arb_pkg: shared constants, tag type and id-width helper for fmul_arbiter
package fmul_arb_pkg;
  localparam int FP32_W = 32;
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fmul_arbiter_if.sv
// fmul_arbiter_if: requester, multiplier and response signals of the shared FP multiplier arbiter
interface fmul_arbiter_if #(parameter int NUM_REQ = 4);
  import fmul_arb_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*FP32_W-1:0] req_a;
  logic [NUM_REQ*FP32_W-1:0] req_b;
  logic [FP32_W-1:0] mul_a;
  logic [FP32_W-1:0] mul_b;
  logic [FP32_W-1:0] mul_out;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [FP32_W-1:0] rsp_data;
  modport slave (
    input req_valid, req_a, req_b, mul_out,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data
  );
  modport master (
    output req_valid, req_a, req_b, mul_out,
    input req_ready, mul_a, mul_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, searching upward from the slot after the last accepted winner
module rr_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic                  accept,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   grant_id
);
  localparam int W = clog2(N);
  logic [W-1:0] last;
  // Scan offsets from farthest to nearest so the nearest valid requester after last wins
  always_comb begin
    grant_id = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) grant_id = W'((int'(last) + k) % N);
    grant = |req ? N'(1) << grant_id : '0;
  end
  // Pointer moves only when the winner is actually accepted; reset makes requester 0 first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= W'(N - 1);
    else if (accept) last <= grant_id;
endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one external FP32 multiplier; optional FMUL_ARB_STATS_EN adds grant counters
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  fmul_arbiter_if.slave bus
`ifdef FMUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
  localparam int ID_W = clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] win;
  logic xfer;
  tag_t pipe [MUL_LAT];
  tag_t tail;
  assign req = rst_n ? bus.req_valid : '0;
  assign xfer = |req;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .accept(xfer),
    .grant(grant),
    .grant_id(win)
  );
  assign bus.req_ready = grant;
  assign bus.mul_a = xfer ? bus.req_a[int'(win)*FP32_W +: FP32_W] : '0;
  assign bus.mul_b = xfer ? bus.req_b[int'(win)*FP32_W +: FP32_W] : '0;
  assign tail = pipe[MUL_LAT-1];
  assign bus.rsp_valid = tail.valid ? NUM_REQ'(1) << tail.id : '0;
  assign bus.rsp_data = tail.valid ? bus.mul_out : '0;
  // Tag pipeline shadows the multiplier so each product returns to its issuer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: xfer, id: TAG_ID_W'(win)};
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
`ifdef FMUL_ARB_STATS_EN
  // Per-requester grant counters that stick at all-ones once saturated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grant_cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: randomized and directed checks of fmul_arbiter against a behavioural model
module tb_fmul_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_g = N - 1;
  typedef struct { int due; int id; logic [31:0] d; } rsp_t;
  rsp_t q[$];
  logic [31:0] mp [L];
  always #5 clk = ~clk;
  fmul_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef FMUL_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif
  fmul_arbiter #(.NUM_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FMUL_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [24:0] r;
    logic g, st;
    int e;
    if (a[30:0] == 0 || b[30:0] == 0) return {a[31] ^ b[31], 31'h0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      r = {1'b0, m[47:24]}; g = m[23]; st = |m[22:0]; e++;
    end else begin
      r = {1'b0, m[46:23]}; g = m[22]; st = |m[21:0];
    end
    if (g && (st || r[0])) r = r + 25'd1;
    if (r[24]) begin r = r >> 1; e++; end
    return {a[31] ^ b[31], e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = rnd_fp();
      bus.req_b[i*32 +: 32] = rnd_fp();
    end
  endtask

  // External multiplier stand-in with fixed latency L
  always @(posedge clk) begin
    mp[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign bus.mul_out = mp[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: round-robin winner, operand forwarding and in-order responses L cycles later
  always @(negedge clk) begin
    logic [N-1:0] er, ev;
    logic [31:0] ea, eb, ed;
    rsp_t r;
    int w;
    er = '0; ev = '0; ea = '0; eb = '0; ed = '0; w = -1;
    if (!rst_n) begin
      q.delete();
      last_g = N - 1;
    end else begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.req_valid[(last_g + k) % N]) w = (last_g + k) % N;
      if (w >= 0) begin
        er[w] = 1'b1;
        ea = bus.req_a[w*32 +: 32];
        eb = bus.req_b[w*32 +: 32];
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        ev[r.id] = 1'b1;
        ed = r.d;
      end
    end
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("mul_a", bus.mul_a, ea);
    check("mul_b", bus.mul_b, eb);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    check("rsp_data", bus.rsp_data, ed);
    if (w >= 0) begin
      q.push_back('{due: cyc + L, id: w, d: fmul(ea, eb)});
      last_g = w;
    end
  end

  initial begin
    drive('0);
    tick(2);
    @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    check("reset_rsp", 32'(bus.rsp_valid), 32'h0);
    tick(1);
    rst_n = 1;
    tick(1);
    // Single request 2.0 * 3.0 from requester 0
    drive(4'b0001);
    bus.req_a[31:0] = 32'h40000000;
    bus.req_b[31:0] = 32'h40400000;
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    check("single_mul_a", bus.mul_a, 32'h40000000);
    tick(1);
    drive('0);
    tick(L - 1);
    @(negedge clk);
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("single_rsp_data", bus.rsp_data, 32'h40C00000);
    tick(1);
    // Fresh reset, then all requesters valid: strict rotation
    rst_n = 0;
    tick(1);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      drive('1);
      @(negedge clk);
      check("rotation_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
      tick(1);
    end
    drive('0);
    tick(L + 1);
    // Requester 2 back-to-back 1.5 * 1.5
    for (int k = 0; k < L + 4; k++) begin
      drive(k < 3 ? 4'b0100 : 4'b0000);
      bus.req_a[64 +: 32] = 32'h3FC00000;
      bus.req_b[64 +: 32] = 32'h3FC00000;
      @(negedge clk);
      if (k >= L && k < L + 3) begin
        check("b2b_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        check("b2b_rsp_data", bus.rsp_data, 32'h40100000);
      end else check("b2b_quiet", 32'(bus.rsp_valid), 32'h0);
      tick(1);
    end
    // Issue on 1 and 3, then reset: in-flight work must vanish
    drive(4'b1010);
    tick(2);
    drive('0);
    rst_n = 0;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp", 32'(bus.rsp_valid), 32'h0);
    tick(1);
    rst_n = 1;
    for (int k = 0; k < L + 1; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus.rsp_valid), 32'h0);
      tick(1);
    end
    drive(4'b1011);
    @(negedge clk);
    check("post_rst_first", 32'(bus.req_ready), 32'h1);
    tick(1);
    // Random traffic with idle cycles
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(2, 0) == 0 ? 4'b0000 : 4'($urandom));
      tick(1);
    end
    drive('0);
    tick(L + 2);
`ifdef FMUL_ARB_STATS_EN
    rst_n = 0;
    tick(1);
    rst_n = 1;
    drive(4'b0001);
    tick(70000);
    drive('0);
    @(negedge clk);
    check("cnt0_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
    check("cnt1_zero", 32'(grant_cnt[31:16]), 32'h0);
    tick(L + 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 2, giving the fixed issue-to-result latency in cycles of the shared multiplier (1..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester grant/accept.
REQ-007 SHALL have port req_a, input, NUM_REQ*32 bits: packed IEEE-754 single operand A (requester i at bits [32i+31:32i]).
REQ-008 SHALL have port req_b, input, NUM_REQ*32 bits: packed operand B, same packing.
REQ-009 SHALL have port mul_a, output, 32 bits: operand A to the shared multiplier.
REQ-010 SHALL have port mul_b, output, 32 bits: operand B to the shared multiplier.
REQ-011 SHALL have port mul_out, input, 32 bits: multiplier product, valid MUL_LAT cycles after issue.
REQ-012 SHALL have port rsp_valid, output, NUM_REQ bits: one-hot result strobe.
REQ-013 SHALL have port rsp_data, output, 32 bits: product, shared by all requesters.

Function
REQ-014 SHALL accept at most one request per cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-015 SHALL assert req_ready combinationally for exactly the round-robin winner among valid requesters, and for no requester when none is valid.
REQ-016 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward, wrapping; last_grant updates only on a transfer.
REQ-017 On a transfer SHALL drive mul_a/mul_b with the winner's operands in the same cycle; with no transfer mul_a/mul_b SHALL be 32'h0.
REQ-018 SHALL carry {valid, id} through a MUL_LAT-deep tag shift register in lockstep with the multiplier pipeline.
REQ-019 When the tag at the final stage is valid, SHALL assert rsp_valid[id] for exactly one cycle with rsp_data = mul_out in that cycle (combinational pass-through).
REQ-020 rsp_valid SHALL be zero and rsp_data SHALL be 32'h0 when the final tag is invalid.
REQ-021 Responses SHALL have no backpressure; requesters SHALL sink rsp_valid unconditionally.
REQ-022 Back-to-back issue SHALL sustain one product per cycle; results return in issue order.
REQ-023 A requester holding req_valid high SHALL be granted within NUM_REQ cycles (starvation bound).
REQ-024 Simultaneous issue and retire in one cycle SHALL both take effect; no conflict exists.

Reset
REQ-025 rst_n low SHALL asynchronously clear all tag valid bits, set last_grant to NUM_REQ-1 (so requester 0 wins first), and clear statistics.
REQ-026 During and after reset, rsp_valid SHALL be 0, and req_ready SHALL be 0 while rst_n is low.
REQ-027 Reset mid-operation SHALL discard in-flight operations; no rsp_valid SHALL fire for them after rst_n releases.

Configuration
REQ-028 Macro FMUL_ARB_STATS_EN, when defined, SHALL add output grant_cnt (NUM_REQ*16 bits), giving per-requester saturating grant counts, cleared on reset and held at 16'hFFFF once saturated.
REQ-029 Without FMUL_ARB_STATS_EN, the grant_cnt port and its counters SHALL be absent.

Structure
REQ-030 Package fmul_arb_pkg SHALL hold the FP32 width constant, the tag struct type {valid, id}, and the ID-width function clog2(NUM_REQ).
REQ-031 SHALL use one sub-module, rr_arbiter (parameterised request vector in, one-hot grant out, pointer update on accept); the multiplier itself SHALL stay external.

Verification
REQ-032 Single request: req0 a=0x40000000 (2.0), b=0x40400000 (3.0) -> rsp_valid=4'b0001 with rsp_data=0x40C00000 exactly MUL_LAT cycles later.
REQ-033 All four valid continuously after reset -> grants in order 0,1,2,3,0,... for 8 cycles, one per cycle, and responses in the same order.
REQ-034 req2 alone with a=b=0x3FC00000 (1.5) for 3 cycles back-to-back -> three rsp_valid[2] pulses on consecutive cycles, each with data 0x40100000.
REQ-035 Issue on req1 and req3, then pulse rst_n low one cycle later -> no rsp_valid pulses occur, and the first post-reset grant goes to req0 if valid.
REQ-036 Idle cycles interleaved with requests -> mul_a=mul_b=0 on idle cycles, with no spurious rsp_valid.
REQ-037 With FMUL_ARB_STATS_EN, 70000 grants to req0 -> grant_cnt[15:0] saturates at 0xFFFF.
